// File: rtl/index_seq_gen_pkg.sv
// Shared types and default sizing for the register-read index sequencer.
// Sized typedefs describe the default configuration.
package index_seq_gen_pkg;

  localparam int DEF_WIDTH_INDEX = 8;
  localparam int DEF_NUM_CH      = 3;
  localparam int DEF_WIDTH_MASK  = 16;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_LINEAR = 2'd1,
    MODE_WINDOW = 2'd2,
    MODE_MASKED = 2'd3
  } idx_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  typedef logic [DEF_WIDTH_INDEX-1:0] index_t;
  typedef index_t [DEF_NUM_CH-1:0]     ch_index_t;
  typedef logic [DEF_WIDTH_MASK-1:0]   mask_t;

endpackage

// File: rtl/index_skip_find.sv
// Single-cycle search for the lowest enabled position at or above a lower bound.
// Positions beyond the held mask bits always count as enabled.
module index_skip_find #(
  parameter int WIDTH_INDEX = 8,
  parameter int WIDTH_MASK  = 16
) (
  input  logic [WIDTH_MASK-1:0]  i_mask,
  input  logic [WIDTH_INDEX-1:0] i_pos,
  input  logic                   i_incl,
  output logic                   o_found,
  output logic [WIDTH_INDEX-1:0] o_pos
);

  localparam int               LP_WE       = WIDTH_INDEX + 1;
  localparam logic [LP_WE-1:0] LP_LIMIT    = LP_WE'({WIDTH_INDEX{1'b1}});
  localparam logic [LP_WE-1:0] LP_MASK_END = LP_WE'(WIDTH_MASK);

  logic [LP_WE-1:0] w_lb;
  logic [LP_WE-1:0] w_tail;

  always_comb begin
    w_lb    = {1'b0, i_pos} + {{WIDTH_INDEX{1'b0}}, ~i_incl};
    // Fallback when no held mask bit qualifies: first position past the mask
    w_tail  = (w_lb > LP_MASK_END) ? w_lb : LP_MASK_END;
    o_found = (w_tail <= LP_LIMIT);
    o_pos   = w_tail[WIDTH_INDEX-1:0];
    for (int j = WIDTH_MASK - 1; j >= 0; j--) begin
      if (i_mask[j] && (LP_WE'(j) >= w_lb)) begin
        o_found = 1'b1;
        o_pos   = WIDTH_INDEX'(j);
      end
    end
  end

endmodule

// File: rtl/index_seq_gen.sv
// Multi-channel register-file index sequencer: one accepted command emits a burst of
// per-element indices in single, linear, 2-D window or mask-skipping mode.
module index_seq_gen
  import index_seq_gen_pkg::*;
#(
  parameter int WIDTH_INDEX = DEF_WIDTH_INDEX,
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int WIDTH_MASK  = DEF_WIDTH_MASK
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_req,
  input  logic                          i_stall,
  input  logic [1:0]                    i_mode,
  input  logic [NUM_CH*WIDTH_INDEX-1:0] i_base,
  input  logic [NUM_CH*WIDTH_INDEX-1:0] i_stride,
  input  logic [NUM_CH*WIDTH_INDEX-1:0] i_pitch,
  input  logic [WIDTH_INDEX-1:0]        i_window,
  input  logic [WIDTH_INDEX-1:0]        i_length,
  input  logic [WIDTH_MASK-1:0]         i_mask,
  input  logic [NUM_CH-1:0]             i_chen,
  output logic                          o_req,
  output logic [NUM_CH*WIDTH_INDEX-1:0] o_index,
  output logic [NUM_CH-1:0]             o_chen,
  output logic [WIDTH_INDEX-1:0]        o_count,
  output logic                          o_last,
  output logic                          o_busy,
  output logic                          o_end
);

  localparam logic [WIDTH_INDEX-1:0] LP_ONE = WIDTH_INDEX'(1);

  state_t                 r_state, w_state_next;
  idx_mode_t              r_mode;
  logic [WIDTH_INDEX-1:0] r_base   [NUM_CH];
  logic [WIDTH_INDEX-1:0] r_stride [NUM_CH];
  logic [WIDTH_INDEX-1:0] r_pitch  [NUM_CH];
  logic [WIDTH_INDEX-1:0] r_row    [NUM_CH];
  logic [WIDTH_INDEX-1:0] r_idx    [NUM_CH];
  logic [WIDTH_INDEX-1:0] r_win, r_len, r_cnt, r_inner;
  logic [WIDTH_MASK-1:0]  r_mask;
  logic [NUM_CH-1:0]      r_chen;
  logic                   r_req, r_last;

  idx_mode_t              w_mode_in;
  logic                   w_is_idle, w_acc, w_zero, w_first_last, w_next_last;
  logic [WIDTH_MASK-1:0]  w_sf_mask;
  logic [WIDTH_INDEX-1:0] w_sf_pos, w_ka, w_kb;
  logic                   w_fa, w_fb;
  logic [WIDTH_INDEX-1:0] w_in_base   [NUM_CH];
  logic [WIDTH_INDEX-1:0] w_in_stride [NUM_CH];
  logic [WIDTH_INDEX-1:0] w_in_pitch  [NUM_CH];
  logic [WIDTH_INDEX-1:0] w_mask_idx  [NUM_CH];

  assign w_mode_in = idx_mode_t'(i_mode);
  assign w_is_idle = (r_state == ST_IDLE);
  assign w_acc     = w_is_idle & i_req & ~i_stall;
  assign w_sf_mask = w_is_idle ? i_mask : r_mask;
  assign w_sf_pos  = w_is_idle ? '0 : r_cnt;

  // Finder A yields the k to emit next; finder B looks one step further for O_Last
  index_skip_find #(.WIDTH_INDEX(WIDTH_INDEX), .WIDTH_MASK(WIDTH_MASK)) u_find_a (
    .i_mask(w_sf_mask), .i_pos(w_sf_pos), .i_incl(w_is_idle), .o_found(w_fa), .o_pos(w_ka)
  );
  index_skip_find #(.WIDTH_INDEX(WIDTH_INDEX), .WIDTH_MASK(WIDTH_MASK)) u_find_b (
    .i_mask(w_sf_mask), .i_pos(w_ka), .i_incl(1'b0), .o_found(w_fb), .o_pos(w_kb)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_in_base[gi]   = i_base[gi*WIDTH_INDEX +: WIDTH_INDEX];
      assign w_in_stride[gi] = i_stride[gi*WIDTH_INDEX +: WIDTH_INDEX];
      assign w_in_pitch[gi]  = i_pitch[gi*WIDTH_INDEX +: WIDTH_INDEX];
      assign w_mask_idx[gi]  = (w_is_idle ? w_in_base[gi] : r_base[gi])
                             + w_ka * (w_is_idle ? w_in_stride[gi] : r_stride[gi]);
      assign o_index[gi*WIDTH_INDEX +: WIDTH_INDEX] = r_idx[gi];
    end
  endgenerate

  always_comb begin
    w_zero       = 1'b0;
    w_first_last = 1'b1;
    case (w_mode_in)
      MODE_SINGLE: begin
        w_zero       = 1'b0;
        w_first_last = 1'b1;
      end
      MODE_MASKED: begin
        w_zero       = ~(w_fa && (w_ka < i_length));
        w_first_last = ~(w_fb && (w_kb < i_length));
      end
      default: begin
        w_zero       = (i_length == '0);
        w_first_last = (i_length == LP_ONE);
      end
    endcase
    if (r_mode == MODE_MASKED) w_next_last = ~(w_fb && (w_kb < r_len));
    else                       w_next_last = ((r_cnt + LP_ONE) == (r_len - LP_ONE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (!i_stall) begin
      case (r_state)
        ST_IDLE: if (i_req) w_state_next = w_zero ? ST_FIN : ST_RUN;
        ST_RUN:  if (r_req && r_last) w_state_next = ST_FIN;
        ST_FIN:  w_state_next = ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy = (r_state != ST_IDLE);
    o_end  = (r_state == ST_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_SINGLE;
      r_win  <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_inner <= '0;
      r_mask <= '0;
      r_chen <= '0;
      r_req  <= 1'b0;
      r_last <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_base[c]   <= '0;
        r_stride[c] <= '0;
        r_pitch[c]  <= '0;
        r_row[c]    <= '0;
        r_idx[c]    <= '0;
      end
    end else if (!i_stall) begin
      if (w_acc) begin
        r_mode  <= w_mode_in;
        r_win   <= (i_window == '0) ? LP_ONE : i_window;
        r_len   <= i_length;
        r_mask  <= i_mask;
        r_chen  <= i_chen;
        r_inner <= '0;
        r_cnt   <= (w_mode_in == MODE_MASKED) ? w_ka : '0;
        r_req   <= ~w_zero;
        r_last  <= w_first_last;
        for (int c = 0; c < NUM_CH; c++) begin
          r_base[c]   <= w_in_base[c];
          r_stride[c] <= w_in_stride[c];
          r_pitch[c]  <= w_in_pitch[c];
          r_row[c]    <= w_in_base[c];
          r_idx[c]    <= (w_mode_in == MODE_MASKED) ? w_mask_idx[c] : w_in_base[c];
        end
      end else if (r_state == ST_RUN) begin
        if (r_last) begin
          r_req  <= 1'b0;
          r_last <= 1'b0;
        end else begin
          r_last <= w_next_last;
          if (r_mode == MODE_MASKED) begin
            r_cnt <= w_ka;
            for (int c = 0; c < NUM_CH; c++) r_idx[c] <= w_mask_idx[c];
          end else begin
            r_cnt <= r_cnt + LP_ONE;
            // Row wrap restarts from the advanced row base instead of the inner stride
            if (r_mode == MODE_WINDOW && r_inner == (r_win - LP_ONE)) begin
              r_inner <= '0;
              for (int c = 0; c < NUM_CH; c++) begin
                r_row[c] <= r_row[c] + r_pitch[c];
                r_idx[c] <= r_row[c] + r_pitch[c];
              end
            end else begin
              r_inner <= r_inner + LP_ONE;
              for (int c = 0; c < NUM_CH; c++) r_idx[c] <= r_idx[c] + r_stride[c];
            end
          end
        end
      end
    end
  end

  assign o_req   = r_req;
  assign o_chen  = r_chen;
  assign o_count = r_cnt;
  assign o_last  = r_last;

endmodule

// File: tb/tb_index_seq_gen.sv
// Directed bench for index_seq_gen: table of commands with hand-computed bursts,
// plus hand-written stall/reset/FIN-stall sequences.
module tb_index_seq_gen;
  import index_seq_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_stall;
  logic [1:0]  i_mode;
  logic [23:0] i_base, i_stride, i_pitch;
  logic [7:0]  i_window, i_length;
  logic [15:0] i_mask;
  logic [2:0]  i_chen;
  logic        o_req, o_last, o_busy, o_end;
  logic [23:0] o_index;
  logic [2:0]  o_chen;
  logic [7:0]  o_count;

  int n_vec;
  int n_err;

  typedef struct packed {
    logic [1:0]       mode;
    logic [7:0]       base;
    logic [7:0]       stride;
    logic [7:0]       pitch;
    logic [7:0]       win;
    logic [7:0]       len;
    logic [15:0]      mask;
    logic [3:0]       n;
    logic [0:7][7:0]  idx;
    logic [0:7][7:0]  cnt;
  } vec_t;

  localparam int NV = 13;
  localparam logic [63:0] CNT_SEQ = {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
  vec_t tbl [NV];
  vec_t v_tmp;

  index_seq_gen dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_stall(i_stall), .i_mode(i_mode),
    .i_base(i_base), .i_stride(i_stride), .i_pitch(i_pitch), .i_window(i_window),
    .i_length(i_length), .i_mask(i_mask), .i_chen(i_chen),
    .o_req(o_req), .o_index(o_index), .o_chen(o_chen), .o_count(o_count),
    .o_last(o_last), .o_busy(o_busy), .o_end(o_end)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic [2:0] chen);
    i_req    = 1'b1;
    i_mode   = v.mode;
    i_base   = {v.base - 8'd1, v.base + 8'd100, v.base};
    i_stride = {3{v.stride}};
    i_pitch  = {3{v.pitch}};
    i_window = v.win;
    i_length = v.len;
    i_mask   = v.mask;
    i_chen   = chen;
  endtask

  task automatic chk_elem(input logic [7:0] idx, input logic [7:0] cnt, input logic last);
    chk("req", 32'(o_req), 32'd1);
    chk("busy", 32'(o_busy), 32'd1);
    chk("idx_ch0", 32'(o_index[7:0]), 32'(idx));
    chk("idx_ch1", 32'(o_index[15:8]), 32'(8'(idx + 8'd100)));
    chk("idx_ch2", 32'(o_index[23:16]), 32'(8'(idx - 8'd1)));
    chk("count", 32'(o_count), 32'(cnt));
    chk("last", 32'(o_last), 32'(last));
  endtask

  task automatic run_cmd(input vec_t v, input logic [2:0] chen);
    drive(v, chen);
    tick();
    i_req = 1'b0;
    chk("chen", 32'(o_chen), 32'(chen));
    for (int e = 0; e < int'(v.n); e++) begin
      chk_elem(v.idx[e], v.cnt[e], (e == int'(v.n) - 1));
      $display("elem mode=%0d k=%0d idx=%0d last=%0d", v.mode, o_count, o_index[7:0], o_last);
      tick();
    end
    chk("req_fin", 32'(o_req), 32'd0);
    chk("end_fin", 32'(o_end), 32'd1);
    chk("busy_fin", 32'(o_busy), 32'd1);
    tick();
    chk("end_idle", 32'(o_end), 32'd0);
    chk("busy_idle", 32'(o_busy), 32'd0);
    $display("cmd mode=%0d base=%0d len=%0d mask=%h elems=%0d done", v.mode, v.base, v.len, v.mask, v.n);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_req"}, 32'(o_req), 32'd0);
    chk({name, "_index"}, 32'(o_index), 32'd0);
    chk({name, "_chen"}, 32'(o_chen), 32'd0);
    chk({name, "_count"}, 32'(o_count), 32'd0);
    chk({name, "_last"}, 32'(o_last), 32'd0);
    chk({name, "_busy"}, 32'(o_busy), 32'd0);
    chk({name, "_end"}, 32'(o_end), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    tbl[0]  = '{mode:MODE_SINGLE, base:8'd5,   stride:8'd7,   pitch:8'd0,  win:8'd0, len:8'd9,
                mask:16'h0000, n:4'd1, idx:{8'd5, 56'd0}, cnt:64'd0};
    tbl[1]  = '{mode:MODE_LINEAR, base:8'd250, stride:8'd3,   pitch:8'd0,  win:8'd0, len:8'd4,
                mask:16'h0000, n:4'd4, idx:{8'd250, 8'd253, 8'd0, 8'd3, 32'd0}, cnt:CNT_SEQ};
    tbl[2]  = '{mode:MODE_WINDOW, base:8'd0,   stride:8'd1,   pitch:8'd16, win:8'd3, len:8'd7,
                mask:16'h0000, n:4'd7, idx:{8'd0, 8'd1, 8'd2, 8'd16, 8'd17, 8'd18, 8'd32, 8'd0}, cnt:CNT_SEQ};
    tbl[3]  = '{mode:MODE_MASKED, base:8'd10,  stride:8'd2,   pitch:8'd0,  win:8'd0, len:8'd20,
                mask:16'h0025, n:4'd7, idx:{8'd10, 8'd14, 8'd20, 8'd42, 8'd44, 8'd46, 8'd48, 8'd0},
                cnt:{8'd0, 8'd2, 8'd5, 8'd16, 8'd17, 8'd18, 8'd19, 8'd0}};
    tbl[4]  = '{mode:MODE_MASKED, base:8'd3,   stride:8'd1,   pitch:8'd0,  win:8'd0, len:8'd10,
                mask:16'h0000, n:4'd0, idx:64'd0, cnt:64'd0};
    tbl[5]  = '{mode:MODE_LINEAR, base:8'd3,   stride:8'd1,   pitch:8'd0,  win:8'd0, len:8'd0,
                mask:16'h0000, n:4'd0, idx:64'd0, cnt:64'd0};
    tbl[6]  = '{mode:MODE_LINEAR, base:8'd2,   stride:8'd255, pitch:8'd0,  win:8'd0, len:8'd4,
                mask:16'h0000, n:4'd4, idx:{8'd2, 8'd1, 8'd0, 8'd255, 32'd0}, cnt:CNT_SEQ};
    tbl[7]  = '{mode:MODE_WINDOW, base:8'd4,   stride:8'd9,   pitch:8'd5,  win:8'd0, len:8'd3,
                mask:16'h0000, n:4'd3, idx:{8'd4, 8'd9, 8'd14, 40'd0}, cnt:CNT_SEQ};
    tbl[8]  = '{mode:MODE_MASKED, base:8'd0,   stride:8'd1,   pitch:8'd0,  win:8'd0, len:8'd17,
                mask:16'h8001, n:4'd3, idx:{8'd0, 8'd15, 8'd16, 40'd0}, cnt:{8'd0, 8'd15, 8'd16, 40'd0}};
    tbl[9]  = '{mode:MODE_MASKED, base:8'd1,   stride:8'd5,   pitch:8'd0,  win:8'd0, len:8'd3,
                mask:16'hFFFE, n:4'd2, idx:{8'd6, 8'd11, 48'd0}, cnt:{8'd1, 8'd2, 48'd0}};
    tbl[10] = '{mode:MODE_WINDOW, base:8'd100, stride:8'd254, pitch:8'd50, win:8'd2, len:8'd5,
                mask:16'h0000, n:4'd5, idx:{8'd100, 8'd98, 8'd150, 8'd148, 8'd200, 24'd0}, cnt:CNT_SEQ};
    tbl[11] = '{mode:MODE_MASKED, base:8'd0,   stride:8'd1,   pitch:8'd0,  win:8'd0, len:8'd2,
                mask:16'h0004, n:4'd0, idx:64'd0, cnt:64'd0};
    tbl[12] = '{mode:MODE_LINEAR, base:8'd0,   stride:8'd128, pitch:8'd0,  win:8'd0, len:8'd3,
                mask:16'h0000, n:4'd3, idx:{8'd0, 8'd128, 8'd0, 40'd0}, cnt:CNT_SEQ};

    // Reset state, with a request asserted that must be ignored
    rst_n = 1'b0;
    i_stall = 1'b0;
    drive(tbl[1], 3'b111);
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    i_req = 1'b0;
    tick();
    chk("post_reset_busy", 32'(o_busy), 32'd0);

    for (int t = 0; t < NV; t++) run_cmd(tbl[t], 3'(t + 1));

    // Stall after the 2nd element, then reset after the 4th
    v_tmp = '{mode:MODE_LINEAR, base:8'd10, stride:8'd1, pitch:8'd0, win:8'd0, len:8'd6,
              mask:16'h0000, n:4'd6, idx:64'd0, cnt:64'd0};
    drive(v_tmp, 3'b101);
    tick();
    i_req = 1'b0;
    chk_elem(8'd10, 8'd0, 1'b0);
    tick();
    chk_elem(8'd11, 8'd1, 1'b0);
    i_stall = 1'b1;
    i_req   = 1'b1;
    i_base  = 24'hFFFFFF;
    for (int s = 0; s < 2; s++) begin
      tick();
      chk_elem(8'd11, 8'd1, 1'b0);
      chk("stall_end", 32'(o_end), 32'd0);
      $display("stall cycle %0d idx=%0d k=%0d", s, o_index[7:0], o_count);
    end
    i_stall = 1'b0;
    i_req   = 1'b0;
    i_base  = {8'd9, 8'd110, 8'd10};
    tick();
    chk_elem(8'd12, 8'd2, 1'b0);
    tick();
    chk_elem(8'd13, 8'd3, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midburst_reset");
    tick();
    chk_all_zero("reset_held");
    rst_n = 1'b1;
    tick();
    chk("after_reset_end", 32'(o_end), 32'd0);
    chk("after_reset_req", 32'(o_req), 32'd0);
    $display("stall/reset sequence done");
    run_cmd(tbl[1], 3'b011);

    // Stall while in FIN holds the completion pulse
    v_tmp = '{mode:MODE_SINGLE, base:8'd7, stride:8'd0, pitch:8'd0, win:8'd0, len:8'd0,
              mask:16'h0000, n:4'd1, idx:64'd0, cnt:64'd0};
    drive(v_tmp, 3'b110);
    tick();
    i_req = 1'b0;
    chk_elem(8'd7, 8'd0, 1'b1);
    tick();
    chk("fin_end", 32'(o_end), 32'd1);
    i_stall = 1'b1;
    for (int s = 0; s < 2; s++) begin
      tick();
      chk("fin_stall_end", 32'(o_end), 32'd1);
      chk("fin_stall_busy", 32'(o_busy), 32'd1);
    end
    i_stall = 1'b0;
    tick();
    chk("fin_release_end", 32'(o_end), 32'd0);
    chk("fin_release_busy", 32'(o_busy), 32'd0);
    $display("FIN stall sequence done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
